noc_pkt_generator: RTL and testbench
====================================

// Module: noc_pkt_generator
// PURPOSE
//  Clocked, parametrised NoC traffic source. Emits packets on a valid/ready port
//  with a programmable inter-packet gap and four payload modes: fixed, LFSR-random,
//  incrementing, and random payload with a fixed destination.
//  Has an optional packet-count limit and a sent counter. Drives router input ports
//  in block- and mesh-level benches, and acts as an on-chip BIST stimulus source.
// PARAMETERS
//  WIDTH_PACKET  14            packet width in bits, 4..32
//  ADDR_W        4             destination field width, packet MSBs; must be < WIDTH_PACKET
//  FL            2             idle gap in cycles between a handshake and the next valid; 0 = back-to-back
//  LFSR_SEED     32'h0000_0001 LFSR reset value; 0 is replaced by 1
//  SEQ_W         4             sequence-number width; used only when PKT_GEN_SEQ_EN is defined
// PORTS
//  clk        in   1             clock; all logic is rising-edge
//  rst_n      in   1             synchronous, active-low reset
//  en         in   1             generation enable (level)
//  mode       in   2             00 FIXED, 01 LFSR, 10 INCR, 11 LFSR_DEST
//  cfg_value  in   WIDTH_PACKET  packet value in FIXED mode
//  cfg_dest   in   ADDR_W        destination in LFSR_DEST mode
//  pkt_limit  in   16            packets per run; 0 = unlimited
//  out_data   out  WIDTH_PACKET  packet
//  out_valid  out  1             packet valid
//  out_ready  in   1             sink ready
//  busy       out  1             high in GAP or SEND
//  done       out  1             high in DONE
//  sent_count out  16            handshakes completed in the current run
// BEHAVIOUR
//  Reset (rst_n=0 at an edge), applies in any state:
//   - state=IDLE; out_data=0, out_valid=0, busy=0, done=0, sent_count=0
//   - lfsr=LFSR_SEED; incr=0
//  FSM states: IDLE, GAP, SEND, DONE. gap_cnt is a counter of width clog2(FL+1).
//   IDLE: if en=1 -> clear sent_count; if FL>0 -> GAP with gap_cnt=FL, else -> SEND.
//   GAP: gap_cnt decrements each cycle.
//    - en=0 -> IDLE; no packet is emitted.
//    - gap_cnt=1 -> SEND.
//   SEND: mode and cfg_* are sampled on entry, and out_data is loaded on the same edge.
//    - out_valid=1. out_data is held stable until out_ready=1.
//    - en=0 does NOT withdraw a pending packet; the handshake always completes.
//   Handshake (out_valid & out_ready at an edge):
//    - sent_count increments; it saturates at 16'hFFFF when pkt_limit=0.
//    - The generator advances: LFSR in modes 01/11, incr in mode 10.
//    - Next state: DONE if pkt_limit!=0 and new sent_count==pkt_limit.
//      Otherwise GAP/SEND per FL if en=1, else IDLE.
//    - out_valid drops on the same edge unless FL=0 and the next state is SEND.
//   DONE: done=1; sent_count is held. en=0 -> IDLE.
//  Payload, sampled on SEND entry:
//   FIXED    : cfg_value
//   LFSR     : lfsr[WIDTH_PACKET-1:0]
//   INCR     : incr; incr is WIDTH_PACKET bits and wraps all-ones -> 0
//   LFSR_DEST: {cfg_dest, lfsr[WIDTH_PACKET-ADDR_W-1:0]}
//  LFSR: 32-bit Galois, lfsr <= (lfsr>>1) ^ (lfsr[0] ? 32'h8020_0003 : 0).
//   A packet carries the current value; the LFSR advances after the handshake.
//  Latency: en rise -> first out_valid = FL+1 cycles (1 cycle when FL=0).
//  A mode change while in SEND takes effect at the next packet.
// CONFIGURATION
//  PKT_GEN_SEQ_EN defined:
//   - out_data[SEQ_W-1:0] is replaced by sent_count[SEQ_W-1:0] in every mode,
//     giving per-run ordering checks.
//   - Requires SEQ_W <= WIDTH_PACKET-ADDR_W.
//  PKT_GEN_SEQ_EN undefined: payload is unmodified and SEQ_W is ignored.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles, any state
//     -> out_valid=0, out_data=0, busy=0, done=0, sent_count=0.
//  2 FIXED, cfg_value=14'h0600, FL=2, pkt_limit=3, out_ready=1, en=1
//     -> three 14'h0600 packets, valid 1 of every 3 cycles; then done=1, sent_count=3.
//  3 Backpressure: out_ready=0 for 5 cycles in SEND
//     -> out_valid=1 and out_data stable; sent_count unchanged; en=0 mid-stall still completes.
//  4 LFSR, seed=1: packets 14'h0001 then 14'h0003.
//    LFSR_DEST, cfg_dest=4'h3: first packet 14'h0C01.
//  5 INCR, WIDTH_PACKET=4, FL=0, pkt_limit=0
//     -> 0..F back-to-back, then 0; sent_count=17 after 17 handshakes.
//  6 en=0 during GAP -> IDLE, no valid.
//    rst_n=0 during SEND -> out_valid=0 after that edge.
//    SEQ_EN: low 4 bits read 0,1,2,...

Source files
------------

// File: rtl/noc_pkt_generator.sv
// ---------------------------------------------------------------------------
// noc_pkt_generator
//   Parametrised NoC traffic source. Emits one packet per valid/ready
//   handshake with a programmable idle gap (FL) between a handshake and the
//   next valid. Four payload modes: fixed value, LFSR-random, incrementing,
//   and LFSR-random with a fixed destination field in the packet MSBs.
//   An optional per-run packet limit parks the generator in DONE.
//
//   Optional build macro: PKT_GEN_SEQ_EN
//     When defined, out_data[SEQ_W-1:0] carries sent_count[SEQ_W-1:0] in every
//     mode (needs SEQ_W <= WIDTH_PACKET-ADDR_W). When undefined the payload
//     is unmodified and SEQ_W has no effect.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   en          in   generation enable (level)
//   mode        in   00 FIXED, 01 LFSR, 10 INCR, 11 LFSR_DEST
//   cfg_value   in   packet value for FIXED
//   cfg_dest    in   destination field for LFSR_DEST
//   pkt_limit   in   packets per run, 0 = unlimited
//   out_data    out  packet
//   out_valid   out  packet valid
//   out_ready   in   sink ready
//   busy        out  high in GAP or SEND
//   done        out  high in DONE
//   sent_count  out  handshakes completed in the current run
// ---------------------------------------------------------------------------
module noc_pkt_generator #(
  parameter int          WIDTH_PACKET = 14,
  parameter int          ADDR_W       = 4,
  parameter int          FL           = 2,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
  parameter int          SEQ_W        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [WIDTH_PACKET-1:0] cfg_value,
  input  logic [ADDR_W-1:0]       cfg_dest,
  input  logic [15:0]             pkt_limit,
  output logic [WIDTH_PACKET-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done,
  output logic [15:0]             sent_count
);

  // A zero-width gap counter is illegal, so FL=0 keeps a 1-bit counter that
  // is never loaded with anything but zero.
  localparam int          GAP_W     = (FL > 0) ? $clog2(FL + 1) : 1;
  localparam logic [31:0] SEED_EFF  = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  generate
    if (WIDTH_PACKET < 4 || WIDTH_PACKET > 32 || ADDR_W < 1 ||
        ADDR_W >= WIDTH_PACKET || SEQ_W < 1) begin : gParamCheck
      $error("noc_pkt_generator: illegal parameter combination");
    end
`ifdef PKT_GEN_SEQ_EN
    if (SEQ_W > WIDTH_PACKET - ADDR_W) begin : gSeqCheck
      $error("noc_pkt_generator: SEQ_W overlaps the destination field");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, GAP, SEND, DONE} stateT;

  stateT                   stateReg, stateNext;
  logic [GAP_W-1:0]        gapReg, gapNext;
  logic [31:0]             lfsrReg, lfsrNext;
  logic [WIDTH_PACKET-1:0] incrReg, incrNext;
  logic [WIDTH_PACKET-1:0] dataReg, payload;
  logic [1:0]              modeReg;
  logic [15:0]             sentReg, sentNext;
  logic                    loadPkt;

  // Next-state logic. loadPkt marks every edge on which SEND is entered
  // (including back-to-back re-entry when FL=0), which is when the payload
  // and mode are captured.
  always_comb begin
    stateNext = stateReg;
    gapNext   = gapReg;
    sentNext  = sentReg;
    lfsrNext  = lfsrReg;
    incrNext  = incrReg;
    loadPkt   = 1'b0;
    case (stateReg)
      IDLE: begin
        if (en) begin
          sentNext = 16'd0;
          if (FL > 0) begin
            stateNext = GAP;
            gapNext   = GAP_W'(FL);
          end else begin
            stateNext = SEND;
            loadPkt   = 1'b1;
          end
        end
      end
      GAP: begin
        if (!en) begin
          stateNext = IDLE;
        end else if (gapReg == GAP_W'(1)) begin
          stateNext = SEND;
          loadPkt   = 1'b1;
        end else begin
          gapNext = gapReg - GAP_W'(1);
        end
      end
      SEND: begin
        // en is deliberately ignored until the handshake completes.
        if (out_ready) begin
          if (pkt_limit == 16'd0 && sentReg == 16'hFFFF) sentNext = sentReg;
          else                                           sentNext = sentReg + 16'd1;
          // Advance follows the mode the current packet was built with.
          if (modeReg[0])
            lfsrNext = (lfsrReg >> 1) ^ (lfsrReg[0] ? LFSR_TAPS : 32'd0);
          if (modeReg == 2'b10)
            incrNext = incrReg + WIDTH_PACKET'(1);
          if (pkt_limit != 16'd0 && sentNext == pkt_limit) begin
            stateNext = DONE;
          end else if (en) begin
            if (FL > 0) begin
              stateNext = GAP;
              gapNext   = GAP_W'(FL);
            end else begin
              stateNext = SEND;
              loadPkt   = 1'b1;
            end
          end else begin
            stateNext = IDLE;
          end
        end
      end
      DONE: begin
        if (!en) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Payload is built from the post-advance generator values so that a
  // back-to-back reload on the handshake edge already sees the next value.
  always_comb begin
    payload = cfg_value;
    case (mode)
      2'b00: payload = cfg_value;
      2'b01: payload = lfsrNext[WIDTH_PACKET-1:0];
      2'b10: payload = incrNext;
      2'b11: payload = {cfg_dest, lfsrNext[WIDTH_PACKET-ADDR_W-1:0]};
      default: payload = cfg_value;
    endcase
`ifdef PKT_GEN_SEQ_EN
    payload[SEQ_W-1:0] = sentNext[SEQ_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      gapReg   <= '0;
      lfsrReg  <= SEED_EFF;
      incrReg  <= '0;
      dataReg  <= '0;
      modeReg  <= 2'b00;
      sentReg  <= 16'd0;
    end else begin
      stateReg <= stateNext;
      gapReg   <= gapNext;
      lfsrReg  <= lfsrNext;
      incrReg  <= incrNext;
      sentReg  <= sentNext;
      if (loadPkt) begin
        dataReg <= payload;
        modeReg <= mode;
      end
    end
  end

  assign out_data   = dataReg;
  assign out_valid  = (stateReg == SEND);
  assign busy       = (stateReg == GAP) || (stateReg == SEND);
  assign done       = (stateReg == DONE);
  assign sent_count = sentReg;

endmodule

// File: tb/tb_noc_pkt_generator.sv
module tb_noc_pkt_generator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: default parameters (14-bit packets, FL=2)
  logic        aRstN, aEn, aValid, aReady, aBusy, aDone;
  logic [1:0]  aMode;
  logic [13:0] aCfgValue, aData;
  logic [3:0]  aCfgDest;
  logic [15:0] aLimit, aSent;

  // Instance B: 4-bit packets, FL=0 (back-to-back)
  logic        bRstN, bEn, bValid, bReady, bBusy, bDone;
  logic [1:0]  bMode;
  logic [3:0]  bCfgValue, bData;
  logic [1:0]  bCfgDest;
  logic [15:0] bLimit, bSent;

  noc_pkt_generator dutA (
    .clk(clk), .rst_n(aRstN), .en(aEn), .mode(aMode),
    .cfg_value(aCfgValue), .cfg_dest(aCfgDest), .pkt_limit(aLimit),
    .out_data(aData), .out_valid(aValid), .out_ready(aReady),
    .busy(aBusy), .done(aDone), .sent_count(aSent)
  );

  noc_pkt_generator #(.WIDTH_PACKET(4), .ADDR_W(2), .FL(0)) dutB (
    .clk(clk), .rst_n(bRstN), .en(bEn), .mode(bMode),
    .cfg_value(bCfgValue), .cfg_dest(bCfgDest), .pkt_limit(bLimit),
    .out_data(bData), .out_valid(bValid), .out_ready(bReady),
    .busy(bBusy), .done(bDone), .sent_count(bSent)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic resetA();
    aRstN = 1'b0; tick(); tick(); aRstN = 1'b1;
  endtask

  initial begin
    aRstN = 1'b0; aEn = 1'b0; aMode = 2'b00; aCfgValue = '0; aCfgDest = '0;
    aLimit = '0; aReady = 1'b0;
    bRstN = 1'b0; bEn = 1'b0; bMode = 2'b00; bCfgValue = '0; bCfgDest = '0;
    bLimit = '0; bReady = 1'b0;

    // 1: reset state
    tick(); tick();
    chk("rst_valid", aValid, 0);
    chk("rst_data",  aData, 0);
    chk("rst_busy",  aBusy, 0);
    chk("rst_done",  aDone, 0);
    chk("rst_sent",  aSent, 0);
    chk("rstB_valid", bValid, 0);
    aRstN = 1'b1; bRstN = 1'b1;
    tick();

    // 2: FIXED, three packets, one valid cycle in every three
    aMode = 2'b00; aCfgValue = 14'h0600; aLimit = 16'd3; aReady = 1'b1; aEn = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk($sformatf("fixed_valid_c%0d", i), aValid, (i % 3 == 0) ? 1 : 0);
      chk($sformatf("fixed_busy_c%0d", i), aBusy, 1);
      if (i % 3 == 0) chk($sformatf("fixed_data_c%0d", i), aData, 14'h0600);
    end
    tick();
    chk("fixed_done", aDone, 1);
    chk("fixed_sent", aSent, 3);
    chk("fixed_valid_done", aValid, 0);
    tick();
    chk("fixed_done_hold", aDone, 1);
    aEn = 1'b0;
    tick();
    chk("fixed_idle_done", aDone, 0);
    chk("fixed_idle_sent", aSent, 3);

    // 3: backpressure, en dropped mid-stall
    aLimit = 16'd0; aReady = 1'b0; aEn = 1'b1;
    tick(); tick();
    chk("bp_latency_valid", aValid, 0);
    tick();
    chk("bp_send_valid", aValid, 1);
    chk("bp_sent_cleared", aSent, 0);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) aEn = 1'b0;
      tick();
      chk($sformatf("bp_stall_valid_%0d", k), aValid, 1);
      chk($sformatf("bp_stall_data_%0d", k), aData, 14'h0600);
      chk($sformatf("bp_stall_sent_%0d", k), aSent, 0);
    end
    aReady = 1'b1;
    tick();
    chk("bp_release_valid", aValid, 0);
    chk("bp_release_sent", aSent, 1);
    chk("bp_release_busy", aBusy, 0);

    // 4: LFSR from seed 1, then LFSR_DEST
    resetA();
    aMode = 2'b01; aLimit = 16'd2; aReady = 1'b1; aEn = 1'b1;
    tick(); tick();
    chk("lfsr_latency", aValid, 0);
    tick();
    chk("lfsr_p0_valid", aValid, 1);
    chk("lfsr_p0_data", aData, 14'h0001);
    tick(); tick(); tick();
    chk("lfsr_p1_valid", aValid, 1);
    chk("lfsr_p1_data", aData, 14'h0003);
    tick();
    chk("lfsr_done", aDone, 1);
    chk("lfsr_sent", aSent, 2);
    aEn = 1'b0;
    tick();
    resetA();
    aMode = 2'b11; aCfgDest = 4'h3; aLimit = 16'd1; aEn = 1'b1;
    tick(); tick(); tick();
    chk("dest_valid", aValid, 1);
    chk("dest_data", aData, 14'h0C01);
    tick();
    chk("dest_done", aDone, 1);
    aEn = 1'b0;
    tick();

    // 5: INCR on the 4-bit, FL=0 instance
    bMode = 2'b10; bLimit = 16'd0; bReady = 1'b1; bEn = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("incr_valid_%0d", i), bValid, 1);
      chk($sformatf("incr_data_%0d", i), bData, i % 16);
      tick();
    end
    chk("incr_sent17", bSent, 17);
    chk("incr_data_after", bData, 4'h1);
    bEn = 1'b0;
    tick();
    chk("incr_idle_valid", bValid, 0);

    // 6: en drop in GAP, reset during SEND
    aMode = 2'b00; aLimit = 16'd0; aReady = 1'b0; aEn = 1'b1;
    tick();
    chk("gap_busy", aBusy, 1);
    aEn = 1'b0;
    tick();
    chk("gap_abort_busy", aBusy, 0);
    tick(); tick();
    chk("gap_abort_valid", aValid, 0);
    aEn = 1'b1;
    tick(); tick(); tick();
    chk("rs_send_valid", aValid, 1);
    aRstN = 1'b0;
    tick();
    chk("rs_valid", aValid, 0);
    chk("rs_data", aData, 0);
    chk("rs_busy", aBusy, 0);
    chk("rs_sent", aSent, 0);
    aRstN = 1'b1; aEn = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
